// File: rtl/channelizer_pkg.sv
// Shared channelizer/synthesizer definitions: sample widths and complex add helpers.
package channelizer_pkg;
  localparam int MAX_FFT_SIZE_WIDTH = 12;
  localparam int SAMPLE_WIDTH       = 16;
  localparam int CPLX_WIDTH         = 2 * SAMPLE_WIDTH;

  typedef logic [SAMPLE_WIDTH-1:0] sample_t;
  typedef logic [CPLX_WIDTH-1:0]   cplx_t;

  function automatic sample_t add_sat(input sample_t a, input sample_t b);
    logic [SAMPLE_WIDTH:0] s;
    s = {a[SAMPLE_WIDTH-1], a} + {b[SAMPLE_WIDTH-1], b};
    if (s[SAMPLE_WIDTH] != s[SAMPLE_WIDTH-1])
      return s[SAMPLE_WIDTH] ? {1'b1, {(SAMPLE_WIDTH-1){1'b0}}} : {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    return s[SAMPLE_WIDTH-1:0];
  endfunction

  // {Q, I} packing: each component added independently.
  function automatic cplx_t cadd_sat(input cplx_t a, input cplx_t b);
    return {add_sat(a[CPLX_WIDTH-1:SAMPLE_WIDTH], b[CPLX_WIDTH-1:SAMPLE_WIDTH]),
            add_sat(a[SAMPLE_WIDTH-1:0], b[SAMPLE_WIDTH-1:0])};
  endfunction

  function automatic cplx_t cadd_wrap(input cplx_t a, input cplx_t b);
    return {sample_t'(a[CPLX_WIDTH-1:SAMPLE_WIDTH] + b[CPLX_WIDTH-1:SAMPLE_WIDTH]),
            sample_t'(a[SAMPLE_WIDTH-1:0] + b[SAMPLE_WIDTH-1:0])};
  endfunction
endpackage

// File: rtl/ola_out_fifo.sv
// Output FIFO with a registered head: data + last, total occupancy on count_o.
module ola_out_fifo #(
  parameter int WIDTH = 33,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       sync_reset,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           din_i,
  input  logic                       ready_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           dout_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      mem_cnt_q;
  logic             out_vld_q;
  logic [WIDTH-1:0] out_q;
  logic             pop, load;

  assign pop     = out_vld_q & ready_i;
  // Head register refills whenever it is empty or being drained this cycle.
  assign load    = (mem_cnt_q != '0) & (~out_vld_q | pop);
  assign valid_o = out_vld_q;
  assign dout_o  = out_q;
  assign count_o = mem_cnt_q + (AW+1)'(out_vld_q);

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= din_i;
  end

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      mem_cnt_q <= '0;
      out_vld_q <= 1'b0;
      out_q     <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (load) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        out_q    <= mem_q[rd_ptr_q];
      end
      out_vld_q <= load | (out_vld_q & ~pop);
      mem_cnt_q <= mem_cnt_q + (AW+1)'(push_i) - (AW+1)'(load);
    end
  end
endmodule

// File: rtl/overlap_add_buffer.sv
// M/2 synthesizer output stage: overlap-adds each frame's first half onto the previous second half.
// OVERLAP_ADD_SAT_EN selects saturating I/Q sums; undefined gives two's-complement wrap.
module overlap_add_buffer
  import channelizer_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int FFT_SIZE_WIDTH = 12,
  parameter int FIFO_DEPTH     = 8
) (
  input  logic                      clk,
  input  logic                      sync_reset,
  input  logic                      s_axis_tvalid,
  input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
  input  logic                      s_axis_tlast,
  output logic                      s_axis_tready,
  input  logic [FFT_SIZE_WIDTH-1:0] fft_size,
  output logic                      m_axis_tvalid,
  output logic [DATA_WIDTH-1:0]     m_axis_tdata,
  output logic                      m_axis_tlast,
  input  logic                      m_axis_tready,
  output logic                      frame_err
);
  localparam int ADDR_WIDTH = FFT_SIZE_WIDTH - 2;
  localparam int STAGES     = 4;
  localparam int CW         = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_WIDTH:0]       k_q, k_d;
  logic [FFT_SIZE_WIDTH-1:0] m_q, m_d, m_eff, half, k_ext;
  logic                      hv_q, hv_d, hv_eff;
  logic                      accept, first, last_k, tl_out, frame_err_q;
  logic [ADDR_WIDTH-1:0]     raddr, waddr;

  logic [DATA_WIDTH-1:0] hist_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rd_pipe_q  [3];
  logic [DATA_WIDTH-1:0] cur_pipe_q [3];
  logic [2:0]            hv_pipe_q;
  logic [STAGES-1:0]     vld_pipe_q, last_pipe_q;
  logic [DATA_WIDTH-1:0] sum_q;

  logic [CW-1:0] fifo_cnt, inflight_q, inflight_d;
  logic [CW:0]   occ;
  logic [DATA_WIDTH:0] fifo_dout;

  assign accept = s_axis_tvalid & s_axis_tready;
  // Frame size is only sampled at k = 0; a size change invalidates the stored half.
  assign m_eff  = (k_q == '0) ? fft_size : m_q;
  assign hv_eff = (k_q == '0 && fft_size != m_q) ? 1'b0 : hv_q;
  assign half   = m_eff >> 1;
  assign k_ext  = FFT_SIZE_WIDTH'(k_q);
  assign first  = k_ext < half;
  assign last_k = k_ext == m_eff - 1'b1;
  assign tl_out = k_ext == half - 1'b1;
  assign raddr  = k_q[ADDR_WIDTH-1:0];
  assign waddr  = ADDR_WIDTH'(k_ext - half);

  always_comb begin
    k_d  = k_q;
    m_d  = m_q;
    hv_d = hv_q;
    if (accept) begin
      m_d  = m_eff;
      hv_d = hv_eff;
      if (s_axis_tlast || last_k) begin
        k_d  = '0;
        hv_d = s_axis_tlast & last_k;
      end else begin
        k_d = k_q + 1'b1;
      end
    end
  end

  // History RAM (read-first) plus its 3-cycle read pipeline and the matching data path.
  always_ff @(posedge clk) begin
    if (accept && !first) hist_q[waddr] <= s_axis_tdata;
    rd_pipe_q[0]  <= hist_q[raddr];
    rd_pipe_q[1]  <= rd_pipe_q[0];
    rd_pipe_q[2]  <= rd_pipe_q[1];
    cur_pipe_q[0] <= s_axis_tdata;
    cur_pipe_q[1] <= cur_pipe_q[0];
    cur_pipe_q[2] <= cur_pipe_q[1];
    hv_pipe_q     <= {hv_pipe_q[1:0], hv_eff};
    last_pipe_q   <= {last_pipe_q[STAGES-2:0], tl_out};
`ifdef OVERLAP_ADD_SAT_EN
    sum_q <= hv_pipe_q[2] ? cadd_sat(cur_pipe_q[2], rd_pipe_q[2]) : cur_pipe_q[2];
`else
    sum_q <= hv_pipe_q[2] ? cadd_wrap(cur_pipe_q[2], rd_pipe_q[2]) : cur_pipe_q[2];
`endif
  end

  assign inflight_d = inflight_q + CW'(accept & first) - CW'(vld_pipe_q[STAGES-1]);

  always_ff @(posedge clk or posedge sync_reset) begin
    if (sync_reset) begin
      k_q         <= '0;
      m_q         <= '0;
      hv_q        <= 1'b0;
      vld_pipe_q  <= '0;
      inflight_q  <= '0;
      frame_err_q <= 1'b0;
    end else begin
      k_q         <= k_d;
      m_q         <= m_d;
      hv_q        <= hv_d;
      vld_pipe_q  <= {vld_pipe_q[STAGES-2:0], accept & first};
      inflight_q  <= inflight_d;
      frame_err_q <= accept & (s_axis_tlast != last_k);
    end
  end

  // Backpressure counts everything already committed to the FIFO, so no tready path.
  assign occ           = {1'b0, fifo_cnt} + {1'b0, inflight_q};
  assign s_axis_tready = !sync_reset && (occ <= (CW+1)'(FIFO_DEPTH - 2));
  assign frame_err     = frame_err_q;

  ola_out_fifo #(.WIDTH(DATA_WIDTH + 1), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk        (clk),
    .sync_reset (sync_reset),
    .push_i     (vld_pipe_q[STAGES-1]),
    .din_i      ({last_pipe_q[STAGES-1], sum_q}),
    .ready_i    (m_axis_tready),
    .valid_o    (m_axis_tvalid),
    .dout_o     (fifo_dout),
    .count_o    (fifo_cnt)
  );

  assign m_axis_tlast = fifo_dout[DATA_WIDTH];
  assign m_axis_tdata = fifo_dout[DATA_WIDTH-1:0];
endmodule

// File: tb/tb_overlap_add_buffer.sv
// Scoreboard bench for overlap_add_buffer: driver pushes expected beats, monitor pops on handshake.
module tb_overlap_add_buffer;
  localparam int FD = 8;

  logic        clk = 1'b0;
  logic        sync_reset;
  logic        s_axis_tvalid, s_axis_tlast, s_axis_tready;
  logic [31:0] s_axis_tdata;
  logic [11:0] fft_size;
  logic        m_axis_tvalid, m_axis_tlast, frame_err;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tready = 1'b1;

  overlap_add_buffer #(.DATA_WIDTH(32), .FFT_SIZE_WIDTH(12), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .sync_reset(sync_reset),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tdata(s_axis_tdata), .s_axis_tlast(s_axis_tlast),
    .s_axis_tready(s_axis_tready), .fft_size(fft_size),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tdata(m_axis_tdata), .m_axis_tlast(m_axis_tlast),
    .m_axis_tready(m_axis_tready), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int          errors = 0, checks = 0;
  int          cyc = 0, err_pulses = 0, ready_viol = 0;
  int          first_acc_cyc = -1, first_vld_cyc = -1;
  bit          rnd_ready = 1'b0, ready_force = 1'b1;
  logic [32:0] sb[$];
  logic [31:0] prev [1024];
  bit          prev_ok = 1'b0;
  int          prev_m = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    m_axis_tready = rnd_ready ? ($urandom_range(0, 9) < 3) : ready_force;
  end

  // Monitor: sb holds every accepted-but-undelivered beat, i.e. FIFO occupancy + in-flight.
  always @(negedge clk) begin
    logic [32:0] exp;
    if (frame_err) err_pulses++;
    if (s_axis_tready && sb.size() > FD - 2) ready_viol++;
    if (!sync_reset && m_axis_tvalid) begin
      if (first_vld_cyc < 0) first_vld_cyc = cyc;
      if (m_axis_tready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got %0h want none", {m_axis_tlast, m_axis_tdata});
        end else begin
          exp = sb.pop_front();
          chk("out", {m_axis_tlast, m_axis_tdata}, exp);
        end
      end
    end
  end

  function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
    int s;
    s = int'($signed(a)) + int'($signed(b));
`ifdef OVERLAP_ADD_SAT_EN
    if (s > 32767) s = 32767;
    else if (s < -32768) s = -32768;
`endif
    return 16'(s);
  endfunction

  function automatic logic [31:0] cadd(input logic [31:0] a, input logic [31:0] b);
    return {add16(a[31:16], b[31:16]), add16(a[15:0], b[15:0])};
  endfunction

  task automatic send(input logic [31:0] d, input bit last, input bit out_en, input logic [32:0] exp);
    int w;
    w = 0;
    s_axis_tvalid = 1'b1; s_axis_tdata = d; s_axis_tlast = last;
    while (!s_axis_tready) begin
      @(posedge clk); #1;
      if (++w > 5000) begin
        $display("FAIL send_timeout: got tready=0 want 1");
        $fatal(1, "input stalled");
      end
    end
    @(posedge clk); #1;
    if (first_acc_cyc < 0) first_acc_cyc = cyc;
    if (out_en) sb.push_back(exp);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
  endtask

  // M = 8 frame with hand-computed first-half outputs e[0..3].
  task automatic hand_frame(input logic [31:0] base, input logic [31:0] step, input logic [3:0][31:0] e);
    logic [31:0] d;
    for (int j = 0; j < 8; j++) begin
      d = base + 32'(j) * step;
      send(d, j == 7, j < 4, {j == 3, (j < 4) ? e[j] : 32'h0});
      if (j >= 4) prev[j-4] = d;
    end
    prev_ok = 1'b1; prev_m = 8;
  endtask

  // err_k < 0: normal; err_k < m-1: early tlast at err_k; err_k == m-1: missing tlast.
  task automatic run_frame(input int m, input int err_k, input int next_fft, input bit rnd,
                           input logic [31:0] base, input logic [31:0] step);
    int len; bit hv; bit last; logic [31:0] d;
    len = (err_k >= 0 && err_k < m - 1) ? err_k + 1 : m;
    hv  = prev_ok && (prev_m == m);
    for (int k = 0; k < len; k++) begin
      d    = rnd ? $urandom : base + 32'(k) * step;
      last = (err_k == m - 1) ? 1'b0 : (k == len - 1);
      if (k == m/2 - 1) fft_size = 12'(next_fft);
      send(d, last, k < m/2, {k == m/2 - 1, hv ? cadd(d, prev[k]) : d});
      if (k >= m/2) prev[k - m/2] = d;
    end
    prev_ok = (err_k < 0); prev_m = m;
  endtask

  task automatic drain(input string name);
    int w;
    w = 0;
    while (sb.size() != 0 && w < 3000) begin @(posedge clk); w++; end
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL %s_drain: got %0d pending want 0", name, sb.size());
    end
    repeat (10) @(posedge clk);
    #1;
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    sync_reset = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = '0; s_axis_tlast = 1'b0; fft_size = 12'd8;
    repeat (3) @(posedge clk); #1;
    chk("rst_s_tready", s_axis_tready, 0);
    chk("rst_m_tvalid", m_axis_tvalid, 0);
    chk("rst_m_tdata", m_axis_tdata, 0);
    chk("rst_m_tlast", m_axis_tlast, 0);
    chk("rst_frame_err", frame_err, 0);
    @(negedge clk); sync_reset = 1'b0; #1;
    chk("rel_s_tready", s_axis_tready, 1);

    // Ramps: raw first frame, then overlap-added second frame.
    hand_frame(32'd1, 32'd1, {32'd4, 32'd3, 32'd2, 32'd1});
    hand_frame(32'd10, 32'd1, {32'd21, 32'd19, 32'd17, 32'd15});
    drain("ramp");
    chk("latency", first_vld_cyc - first_acc_cyc, 5);

    // Overflowing I (+30000 twice) and Q (-30000 twice).
    hand_frame(32'h8AD0_7530, 32'd0, {32'h8AD0_7541, 32'h8AD0_7540, 32'h8AD0_753F, 32'h8AD0_753E});
`ifdef OVERLAP_ADD_SAT_EN
    hand_frame(32'h8AD0_7530, 32'd0, {4{32'h8000_7FFF}});
`else
    hand_frame(32'h8AD0_7530, 32'd0, {4{32'h15A0_EA60}});
`endif
    drain("sat");

    // Backpressure: 50 random frames at M = 64 with 30% downstream ready.
    fft_size = 12'd64;
    rnd_ready = 1'b1;
    for (int f = 0; f < 50; f++) run_frame(64, -1, 64, 1'b1, 32'h0, 32'h0);
    drain("random");
    rnd_ready = 1'b0;
    repeat (2) @(posedge clk); #1;
    chk("ready_bound_viol", ready_viol, 0);

    // Framing errors: early tlast at k = 5, then missing tlast at k = 7.
    fft_size = 12'd8;
    run_frame(8, -1, 8, 1'b0, 32'h0001_0100, 32'h0001_0001);
    run_frame(8, -1, 8, 1'b0, 32'h0020_0200, 32'h0002_0003);
    e0 = err_pulses;
    run_frame(8, 5, 8, 1'b0, 32'h0030_0300, 32'h0001_0005);
    drain("early_tlast");
    chk("early_tlast_pulses", err_pulses - e0, 1);
    run_frame(8, -1, 8, 1'b0, 32'h0040_0400, 32'h0003_0001);
    e0 = err_pulses;
    run_frame(8, 7, 8, 1'b0, 32'h0050_0500, 32'h0001_0002);
    run_frame(8, -1, 8, 1'b0, 32'h0060_0600, 32'h0001_0001);
    drain("missing_tlast");
    chk("missing_tlast_pulses", err_pulses - e0, 1);

    // fft_size 8 -> 16 in the middle of a frame.
    e0 = err_pulses;
    run_frame(8, -1, 16, 1'b0, 32'h0070_0700, 32'h0001_0001);
    run_frame(16, -1, 16, 1'b0, 32'h0080_0800, 32'h0002_0001);
    run_frame(16, -1, 16, 1'b0, 32'h0090_0900, 32'h0001_0003);
    drain("size_change");
    chk("size_change_pulses", err_pulses - e0, 0);

    // Reset with three beats parked in the FIFO.
    fft_size = 12'd8;
    run_frame(8, -1, 8, 1'b0, 32'h00A0_0A00, 32'h0001_0001);
    run_frame(8, -1, 8, 1'b0, 32'h00B0_0B00, 32'h0001_0001);
    drain("pre_reset");
    ready_force = 1'b0;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) send(32'h00C0_0C00 + 32'(k), 1'b0, 1'b1, 33'h0);
    repeat (8) @(posedge clk); #1;
    chk("parked_valid", m_axis_tvalid, 1);
    @(negedge clk); sync_reset = 1'b1; #1;
    chk("reset_m_tvalid", m_axis_tvalid, 0);
    chk("reset_s_tready", s_axis_tready, 0);
    sb.delete();
    prev_ok = 1'b0;
    ready_force = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk); sync_reset = 1'b0; #1;
    chk("rerel_s_tready", s_axis_tready, 1);
    run_frame(8, -1, 8, 1'b0, 32'h00D0_0D00, 32'h0001_0002);
    run_frame(8, -1, 8, 1'b0, 32'h00E0_0E00, 32'h0002_0001);
    drain("post_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
